// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI constants and controller state encoding
//   SPI_WIDTH        - bits per transfer
//   SPI_CPOL/CPHA    - mode 0: sck idles low, data sampled on rising sck
//   spi_ctrl_state_t - controller FSM states
package spi_pkg;
    localparam int SPI_WIDTH = 8;
    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;
    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} spi_ctrl_state_t;
endpackage

// File: rtl/spi_controller_if.sv
// spi_controller_if: request/response and serial pins of the SPI controller
//   start/din        - transfer request and byte to send
//   busy/done/dout   - transfer status and received byte
//   sck/ss/mosi/miso - serial link
//   master modport is the controller side, slave modport is the user/link side
interface spi_controller_if;
    import spi_pkg::*;
    logic                 start;
    logic [SPI_WIDTH-1:0] din;
    logic                 busy;
    logic                 done;
    logic [SPI_WIDTH-1:0] dout;
    logic                 sck;
    logic                 ss;
    logic                 mosi;
    logic                 miso;
    modport master(input start, din, miso, output busy, done, dout, sck, ss, mosi);
    modport slave(output start, din, miso, input busy, done, dout, sck, ss, mosi);
endinterface

// File: rtl/spi_half_period_tick.sv
// spi_half_period_tick: pulses tick on every CLK_DIV-th cycle while en is high
//   clk, rst - system clock, async active-high reset
//   en       - count enable; counter clears while low
//   tick     - high in the last cycle of each CLK_DIV-cycle window
module spi_half_period_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [CW-1:0] cnt;
    assign tick = en && cnt == CW'(CLK_DIV - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else     cnt <= (!en || tick) ? '0 : cnt + CW'(1);
endmodule

// File: rtl/spi_controller.sv
// spi_controller: 8-bit MSB-first mode-0 SPI master, sck half-period CLK_DIV cycles
//   clk, rst - system clock, async active-high reset
//   bus      - spi_controller_if.master: start/din in, busy/done/dout out,
//              sck/ss/mosi out, miso in
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    spi_controller_if.master bus
);
    localparam logic [2:0] LAST = 3'(SPI_WIDTH - 1);
    spi_ctrl_state_t state, state_n;
    logic [SPI_WIDTH-1:0] tx, tx_n, rx, rx_n, dout, dout_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic sck, sck_n, ss, ss_n, mosi, mosi_n, busy, busy_n, done, done_n;
    logic tick, accept;

    spi_half_period_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (state != IDLE),
        .tick(tick)
    );

    // the edge that ends GAP is also the first IDLE edge, so a held start
    // restarts immediately and a byte takes exactly 18 half-periods
    assign accept = bus.start && (state == IDLE || (state == GAP && tick));

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            tx      <= '0;
            rx      <= '0;
            bit_cnt <= '0;
            sck     <= SPI_CPOL;
            ss      <= 1'b1;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dout    <= '0;
        end else begin
            state   <= state_n;
            tx      <= tx_n;
            rx      <= rx_n;
            bit_cnt <= bit_cnt_n;
            sck     <= sck_n;
            ss      <= ss_n;
            mosi    <= mosi_n;
            busy    <= busy_n;
            done    <= done_n;
            dout    <= dout_n;
        end

    always_comb begin
        state_n = state;
        if (accept)
            state_n = SETUP;
        else if (tick)
            case (state)
                SETUP, LOW: state_n = HIGH;
                HIGH:       state_n = bit_cnt == LAST ? HOLD : LOW;
                HOLD:       state_n = GAP;
                GAP:        state_n = IDLE;
                default:    state_n = state;
            endcase
    end

    always_comb begin
        tx_n      = tx;
        rx_n      = rx;
        bit_cnt_n = bit_cnt;
        sck_n     = sck;
        ss_n      = ss;
        mosi_n    = mosi;
        busy_n    = busy;
        done_n    = 1'b0;
        dout_n    = dout;
        if (accept) begin
            tx_n   = bus.din;
            ss_n   = 1'b0;
            mosi_n = bus.din[SPI_WIDTH-1];
            busy_n = 1'b1;
        end else if (tick)
            case (state)
                SETUP, LOW: begin
                    sck_n = 1'b1;
                    rx_n  = {rx[SPI_WIDTH-2:0], bus.miso};
                end
                HIGH: begin
                    sck_n     = 1'b0;
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt != LAST) begin
                        tx_n   = {tx[SPI_WIDTH-2:0], 1'b0};
                        mosi_n = tx[SPI_WIDTH-2];
                    end
                end
                HOLD: begin
                    ss_n   = 1'b1;
                    dout_n = rx;
                    done_n = 1'b1;
                    mosi_n = 1'b0;
                end
                GAP:     busy_n = 1'b0;
                default: ;
            endcase
    end

    assign bus.sck  = sck;
    assign bus.ss   = ss;
    assign bus.mosi = mosi;
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.dout = dout;
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: scoreboard bench for spi_controller at CLK_DIV=2 and CLK_DIV=1
module tb_spi_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;
    logic       loop = 1'b1;
    logic       per_miso = 1'b0;
    logic [7:0] p_tx = 8'h00;
    logic [7:0] p_rx = 8'h00;
    logic [7:0] p_dout = 8'h00;
    int         p_bits = 0;
    logic       p_done = 1'b0;
    logic       sck2_prev = 1'b0;
    logic       ss2_prev = 1'b1;
    logic       sck1_prev = 1'b0;
    int         rise2[$];
    int         done2q[$];
    int         rise1[$];
    int         fall1[$];
    logic [7:0] sb2[$];
    logic [7:0] sb1[$];

    spi_controller_if b2();
    spi_controller_if b1();
    assign b2.miso = loop ? b2.mosi : per_miso;
    assign b1.miso = b1.mosi;

    spi_controller #(.CLK_DIV(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.master));
    spi_controller #(.CLK_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.master));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // edge recorder plus mode-0 peripheral model on dut2 (sends 8'h96)
    always @(negedge clk) begin
        if (!b2.ss && ss2_prev) begin
            p_tx = 8'h96;
            per_miso = p_tx[7];
            p_bits = 0;
            p_done = 1'b0;
        end
        if (b2.sck && !sck2_prev) begin
            rise2.push_back(cyc);
            p_rx = {p_rx[6:0], b2.mosi};
            p_bits++;
            if (p_bits == 8) begin
                p_done = 1'b1;
                p_dout = p_rx;
            end
        end
        if (!b2.sck && sck2_prev) begin
            p_tx = {p_tx[6:0], 1'b0};
            per_miso = p_tx[7];
        end
        if (b2.done) done2q.push_back(cyc);
        if (b1.sck && !sck1_prev) rise1.push_back(cyc);
        if (!b1.sck && sck1_prev) fall1.push_back(cyc);
        sck2_prev = b2.sck;
        ss2_prev = b2.ss;
        sck1_prev = b1.sck;
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_total++; if (b2.sck !== 1'b0) $display("FAIL reset_sck: got %b want 0", b2.sck); else n_pass++;
        n_total++; if (b2.ss !== 1'b1) $display("FAIL reset_ss: got %b want 1", b2.ss); else n_pass++;
        n_total++; if (b2.mosi !== 1'b0) $display("FAIL reset_mosi: got %b want 0", b2.mosi); else n_pass++;
        n_total++; if (b2.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", b2.busy); else n_pass++;
        n_total++; if (b2.done !== 1'b0) $display("FAIL reset_done: got %b want 0", b2.done); else n_pass++;
        n_total++; if (b2.dout !== 8'h00) $display("FAIL reset_dout: got %h want 00", b2.dout); else n_pass++;
        n_total++; if (b1.ss !== 1'b1 || b1.sck !== 1'b0) $display("FAIL reset_dut1_pins: got ss=%b sck=%b want ss=1 sck=0", b1.ss, b1.sck); else n_pass++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (b2.busy !== 1'b0 || b2.ss !== 1'b1) $display("FAIL idle_after_reset: got busy=%b ss=%b want busy=0 ss=1", b2.busy, b2.ss); else n_pass++;
    endtask

    task automatic test_loopback();
        int t0;
        loop = 1'b1;
        rise2.delete();
        @(negedge clk);
        b2.din = 8'hA5;
        b2.start = 1'b1;
        t0 = cyc + 1;
        sb2.push_back(8'hA5);
        @(negedge clk);
        b2.start = 1'b0;
        b2.din = 8'h00;
        n_total++; if (b2.ss !== 1'b0 || b2.busy !== 1'b1 || b2.mosi !== 1'b1) $display("FAIL loopback_accept: got ss=%b busy=%b mosi=%b want 0 1 1", b2.ss, b2.busy, b2.mosi); else n_pass++;
        for (int i = 0; i < 100 && !b2.done; i++) @(negedge clk);
        n_total++; if (b2.done !== 1'b1 || cyc - t0 != 34) $display("FAIL loopback_done_cycle: got done=%b at cycle %0d want done=1 at 34", b2.done, cyc - t0); else n_pass++;
        begin
            logic [7:0] exp = sb2.pop_front();
            n_total++; if (b2.dout !== exp) $display("FAIL loopback_dout: got %h want %h", b2.dout, exp); else n_pass++;
        end
        n_total++; if (b2.ss !== 1'b1) $display("FAIL loopback_ss_at_done: got %b want 1", b2.ss); else n_pass++;
        wait_cyc(t0 + 35);
        n_total++; if (b2.busy !== 1'b1) $display("FAIL loopback_busy_35: got %b want 1", b2.busy); else n_pass++;
        wait_cyc(t0 + 36);
        n_total++; if (b2.busy !== 1'b0) $display("FAIL loopback_busy_36: got %b want 0", b2.busy); else n_pass++;
        n_total++; if (rise2.size() != 8) $display("FAIL loopback_rise_count: got %0d want 8", rise2.size()); else n_pass++;
        for (int i = 0; i < rise2.size() && i < 8; i++) begin
            n_total++; if (rise2[i] - t0 != 2 + 4 * i) $display("FAIL loopback_rise%0d: got cycle %0d want %0d", i + 1, rise2[i] - t0, 2 + 4 * i); else n_pass++;
        end
    endtask

    task automatic test_peripheral();
        int t0;
        loop = 1'b0;
        @(negedge clk);
        b2.din = 8'h3C;
        b2.start = 1'b1;
        t0 = cyc + 1;
        sb2.push_back(8'h96);
        @(negedge clk);
        b2.start = 1'b0;
        for (int i = 0; i < 100 && !b2.done; i++) @(negedge clk);
        n_total++; if (b2.done !== 1'b1) $display("FAIL periph_done: got %b want 1 (timeout)", b2.done); else n_pass++;
        begin
            logic [7:0] exp = sb2.pop_front();
            n_total++; if (b2.dout !== exp) $display("FAIL periph_ctrl_dout: got %h want %h", b2.dout, exp); else n_pass++;
        end
        n_total++; if (p_done !== 1'b1 || p_dout !== 8'h3C) $display("FAIL periph_rx: got done=%b dout=%h want done=1 dout=3c", p_done, p_dout); else n_pass++;
        wait_cyc(t0 + 37);
        loop = 1'b1;
    endtask

    task automatic test_busy_reject();
        int t0;
        rise2.delete();
        done2q.delete();
        @(negedge clk);
        b2.din = 8'h11;
        b2.start = 1'b1;
        t0 = cyc + 1;
        sb2.push_back(8'h11);
        @(negedge clk);
        b2.start = 1'b0;
        wait_cyc(t0 + 10);
        b2.din = 8'hFF;
        b2.start = 1'b1;
        @(negedge clk);
        b2.start = 1'b0;
        b2.din = 8'h00;
        for (int i = 0; i < 100 && !b2.done; i++) @(negedge clk);
        n_total++; if (b2.done !== 1'b1 || cyc - t0 != 34) $display("FAIL busy_done_cycle: got done=%b at cycle %0d want done=1 at 34", b2.done, cyc - t0); else n_pass++;
        begin
            logic [7:0] exp = sb2.pop_front();
            n_total++; if (b2.dout !== exp) $display("FAIL busy_dout: got %h want %h", b2.dout, exp); else n_pass++;
        end
        wait_cyc(t0 + 80);
        n_total++; if (rise2.size() != 8) $display("FAIL busy_rise_count: got %0d want 8", rise2.size()); else n_pass++;
        n_total++; if (done2q.size() != 1) $display("FAIL busy_done_count: got %0d want 1", done2q.size()); else n_pass++;
        n_total++; if (b2.busy !== 1'b0 || b2.ss !== 1'b1 || b2.dout !== 8'h11) $display("FAIL busy_idle_after: got busy=%b ss=%b dout=%h want 0 1 11", b2.busy, b2.ss, b2.dout); else n_pass++;
    endtask

    task automatic test_reset_abort();
        int t0;
        rise2.delete();
        done2q.delete();
        @(negedge clk);
        b2.din = 8'hC3;
        b2.start = 1'b1;
        @(negedge clk);
        b2.start = 1'b0;
        for (int i = 0; i < 100 && rise2.size() < 3; i++) @(negedge clk);
        n_total++; if (rise2.size() != 3) $display("FAIL abort_third_rise: got %0d rises want 3", rise2.size()); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++; if (b2.ss !== 1'b1 || b2.sck !== 1'b0 || b2.busy !== 1'b0) $display("FAIL abort_async_pins: got ss=%b sck=%b busy=%b want 1 0 0", b2.ss, b2.sck, b2.busy); else n_pass++;
        n_total++; if (b2.dout !== 8'h00 || b2.mosi !== 1'b0) $display("FAIL abort_async_dout: got dout=%h mosi=%b want 00 0", b2.dout, b2.mosi); else n_pass++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        n_total++; if (done2q.size() != 0) $display("FAIL abort_no_done: got %0d done pulses want 0", done2q.size()); else n_pass++;
        rise2.delete();
        b2.din = 8'h5A;
        b2.start = 1'b1;
        t0 = cyc + 1;
        sb2.push_back(8'h5A);
        @(negedge clk);
        b2.start = 1'b0;
        for (int i = 0; i < 100 && !b2.done; i++) @(negedge clk);
        n_total++; if (b2.done !== 1'b1 || cyc - t0 != 34) $display("FAIL abort_retry_done: got done=%b at cycle %0d want done=1 at 34", b2.done, cyc - t0); else n_pass++;
        begin
            logic [7:0] exp = sb2.pop_front();
            n_total++; if (b2.dout !== exp) $display("FAIL abort_retry_dout: got %h want %h", b2.dout, exp); else n_pass++;
        end
        n_total++; if (rise2.size() != 8) $display("FAIL abort_retry_rises: got %0d want 8", rise2.size()); else n_pass++;
        wait_cyc(t0 + 40);
    endtask

    task automatic test_back_to_back();
        int t0;
        rise1.delete();
        fall1.delete();
        @(negedge clk);
        b1.din = 8'h01;
        b1.start = 1'b1;
        t0 = cyc + 1;
        sb1.push_back(8'h01);
        sb1.push_back(8'h80);
        @(negedge clk);
        b1.din = 8'h80;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 60 && !b1.done; i++) @(negedge clk);
            n_total++; if (b1.done !== 1'b1 || cyc - t0 != 17 + 18 * d) $display("FAIL b2b_done%0d_cycle: got done=%b at cycle %0d want done=1 at %0d", d, b1.done, cyc - t0, 17 + 18 * d); else n_pass++;
            begin
                logic [7:0] exp = sb1.pop_front();
                n_total++; if (b1.dout !== exp) $display("FAIL b2b_dout%0d: got %h want %h", d, b1.dout, exp); else n_pass++;
            end
            n_total++; if (b1.ss !== 1'b1) $display("FAIL b2b_ss_gap%0d: got %b want 1", d, b1.ss); else n_pass++;
            @(negedge clk);
            if (d == 0) b1.start = 1'b0;
            n_total++; if (b1.ss !== (d == 0 ? 1'b0 : 1'b1)) $display("FAIL b2b_ss_after%0d: got %b want %b", d, b1.ss, d == 0 ? 1'b0 : 1'b1); else n_pass++;
        end
        wait_cyc(t0 + 40);
        n_total++; if (rise1.size() != 16 || fall1.size() != 16) $display("FAIL b2b_edge_count: got rises=%0d falls=%0d want 16 16", rise1.size(), fall1.size()); else n_pass++;
        n_total++; if (b1.busy !== 1'b0) $display("FAIL b2b_busy_end: got %b want 0", b1.busy); else n_pass++;
        for (int i = 0; i < rise1.size() && i < fall1.size() && i < 16; i++) begin
            n_total++; if (rise1[i] - t0 != 18 * (i / 8) + 2 * (i % 8) + 1) $display("FAIL b2b_rise%0d: got cycle %0d want %0d", i, rise1[i] - t0, 18 * (i / 8) + 2 * (i % 8) + 1); else n_pass++;
            n_total++; if (fall1[i] - rise1[i] != 1) $display("FAIL b2b_high%0d: got %0d cycles want 1", i, fall1[i] - rise1[i]); else n_pass++;
            if (i % 8 != 7 && i + 1 < rise1.size()) begin
                n_total++; if (rise1[i + 1] - fall1[i] != 1) $display("FAIL b2b_low%0d: got %0d cycles want 1", i, rise1[i + 1] - fall1[i]); else n_pass++;
            end
        end
    endtask

    initial begin
        b2.start = 1'b0;
        b2.din = 8'h00;
        b1.start = 1'b0;
        b1.din = 8'h00;
        test_reset();
        test_loopback();
        test_peripheral();
        test_busy_reject();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/spi_controller.md
# spi_controller

SPI controller (master) for the SPI links in the communication subsystem. It is the initiating end for `spi_peripheral`. On a `start` request it runs one 8-bit, MSB-first, mode-0 (CPOL=0, CPHA=0) full-duplex transfer. It generates `sck` from the system clock, frames the transfer with `ss`, and returns the received byte with a one-cycle `done` pulse.

## Interface
- `CLK_DIV`, default 4: `sck` half-period in `clk` cycles; legal range ≥ 1.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  transfer request; sampled only while `busy`=0.
- `din`  in  8  byte to transmit; captured on the accepting edge.
- `busy`  out  1  high from the accepting edge until the controller can accept the next `start`.
- `done`  out  1  one-cycle pulse; `dout` is valid from this cycle onward.
- `dout`  out  8  last received byte; holds until the next `done`.
- `sck`  out  1  serial clock; idles low.
- `ss`  out  1  active-low select; idles high.
- `mosi`  out  1  serial data out, MSB first.
- `miso`  in  1  serial data in; the peripheral changes it after falling `sck`.

## Operation
- Reset values: `sck`=0, `ss`=1, `mosi`=0, `busy`=0, `done`=0, `dout`=8'h00, state IDLE, all counters 0.
- Let H = `CLK_DIV`. A half-period counter counts 0..H-1. A 3-bit bit counter wraps from 7 to 0.
- **IDLE**
  - When `start`=1, load `din` into the shift register, drive `ss`←0, `mosi`←`din[7]`, `busy`←1, and go to SETUP.
- **SETUP** (H cycles)
  - `ss` is low and `sck` is low, so MOSI settles before the first edge.
  - Then `sck`←1 and go to HIGH.
- **HIGH** (H cycles)
  - On the edge that raised `sck`, shift `miso` into the receive register LSB.
  - At the end of HIGH, `sck`←0.
  - If bit counter = 7, go to HOLD.
  - Otherwise, increment the bit counter, drive the next MSB on `mosi`, and go to LOW.
- **LOW** (H cycles)
  - Then `sck`←1 and go to HIGH.
- **HOLD** (H cycles)
  - Then `ss`←1, `dout`←receive register, `done`←1 for one cycle, `mosi`←0, and go to GAP.
- **GAP** (H cycles)
  - `ss` stays high; this enforces the minimum deselect time.
  - Then `busy`←0 and go to IDLE.
- `start` while `busy`=1 is ignored. It is not queued.
- `start` held continuously yields back-to-back transfers. Each new transfer is accepted on the first IDLE cycle.
- Asynchronous `rst` during a transfer immediately forces all reset values. The transfer is aborted, no `done` is produced, and `dout` clears to 0.
- Exactly 8 rising `sck` edges occur per transfer. No glitch or runt `sck` pulses occur, including for `CLK_DIV`=1.

## Timing
- Take the accepting edge as cycle 0.
- `ss` falls at cycle 0.
- The k-th `sck` rise (k = 1..8) is at cycle H·(2k−1).
- The k-th `sck` fall is at cycle 2kH.
- The last `sck` fall is at 16H.
- `ss` rises and `done` is high at cycle 17H.
- `busy` falls at 18H. The next transfer can be accepted at 18H, so there are 18H cycles per byte.
- `mosi` changes only at cycle 0 and on `sck` falls. It is stable for H cycles before each `sck` rise.
- `miso` is sampled coincident with each `sck` rise. The peripheral has had ≥ H cycles since its update.
- `done` and `dout` are registered outputs. There is no combinational path from `miso` or `start` to any output.

## Structure
- The shared package `spi_pkg` holds:
  - `SPI_WIDTH` = 8.
  - `typedef enum` `spi_ctrl_state_t` {IDLE, SETUP, HIGH, LOW, HOLD, GAP}.
  - The mode constants (CPOL=0, CPHA=0).
- One sub-module, `spi_half_period_tick`.
  - Parameter `CLK_DIV`, inputs `clk`, `rst`, and `en`, output `tick`.
  - `tick` pulses every H cycles while enabled and clears when `en`=0.
  - The controller FSM advances on `tick`.

## Test plan
- **Loopback.** `CLK_DIV`=2, `mosi` tied to `miso`, `din`=8'hA5, `start` for 1 cycle. Required: 8 `sck` rises at cycles 2, 6, …, 30; `done` at cycle 34 with `dout`=8'hA5; `busy` low at cycle 36.
- **Against the peripheral model.** `spi_peripheral` attached, `din`=8'h3C. Required: peripheral `dout`=8'h3C with its `done` asserted. The model drives `miso` as 8'h96 MSB-first, updating on `sck` falls. Required: controller `dout`=8'h96.
- **Busy rejection.** Pulse `start` with 8'hFF mid-transfer of 8'h11. Required: the first transfer completes unchanged with exactly 8 `sck` rises, and no second transfer follows.
- **Reset abort.** Assert `rst` after the 3rd `sck` rise. Required: in the same cycle (asynchronously) `ss`=1, `sck`=0, `busy`=0, `dout`=0; no `done` pulse. After release, a transfer of 8'h5A completes correctly.
- **Back-to-back.** `CLK_DIV`=1, `start` held high, `din` = 8'h01 then 8'h80. Required: two `done` pulses 18 cycles apart, `ss` high for ≥ 1 cycle between transfers, and 16 total `sck` rises, each with high and low phases exactly 1 cycle.
